// File: rtl/dmem_ctrl.sv
// Handshaked, byte-addressed, little-endian data-memory controller for the CPU load/store path.
// Supports byte/half/word accesses with sign extension, programmable wait states and alignment errors.
module dmem_ctrl #(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int unsigned DEPTH     = 2 ** (ADDR_W - 2);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                sign_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;

    logic [31:0]         mem [DEPTH];

    logic                accept;
    logic [ADDR_W-3:0]   word_idx;
    logic [1:0]          lane;
    logic [31:0]         rd_word;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [3:0]          be;
    logic [31:0]         wr_lanes;
    logic [31:0]         load_val;
    logic                misaligned;
    logic                do_write;

    assign req_ready  = (state_q == StIdle) || (state_q == StResp);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StResp: begin
                if (accept) begin
                    if (WAIT_CYCLES != 0) begin
                        state_d = StWait;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = StAccess;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StAccess;
                end
            end
            StAccess: state_d = StResp;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                size_q  <= req_size;
                sign_q  <= req_sign;
                wdata_q <= req_wdata;
            end
            if (state_q == StAccess) begin
                rdata_q <= (we_q || misaligned) ? 32'h0 : load_val;
                err_q   <= misaligned;
            end
        end
    end

    assign word_idx   = addr_q[ADDR_W-1:2];
    assign lane       = addr_q[1:0];
    assign rd_word    = mem[word_idx];
    assign misaligned = (size_q == 2'd3) ||
                        ((size_q == 2'd1) && addr_q[0]) ||
                        ((size_q == 2'd2) && (addr_q[1:0] != 2'd0));
    assign do_write   = (state_q == StAccess) && we_q && !misaligned;

    // Store data is replicated across lanes so the byte enables alone pick the target lanes.
    always_comb begin
        be       = 4'b0000;
        wr_lanes = 32'h0;
        load_val = 32'h0;
        byte_sel = rd_word[{lane, 3'b000} +: 8];
        half_sel = rd_word[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'd0: begin
                be       = 4'b0001 << lane;
                wr_lanes = {4{wdata_q[7:0]}};
                load_val = {{24{sign_q & byte_sel[7]}}, byte_sel};
            end
            2'd1: begin
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
                load_val = {{16{sign_q & half_sel[15]}}, half_sel};
            end
            2'd2: begin
                be       = 4'b1111;
                wr_lanes = wdata_q;
                load_val = rd_word;
            end
            default: ;
        endcase
    end

    // No reset on the array; gating with rst_n keeps a write from landing on a reset edge.
    always_ff @(posedge clk) begin
        if (rst_n && do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance with no wait states and one with three, shared request bus.
// A byte-array model predicts every load result, error flag and response latency.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid0, valid3;
    logic        req_we;
    logic [10:0] req_addr;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_wdata;

    logic        ready0, rv0, err0, busy0;
    logic [31:0] rd0;
    logic        ready3, rv3, err3, busy3;
    logic [31:0] rd3;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_model [2][2048];

    dmem_ctrl #(.ADDR_W(11), .WAIT_CYCLES(0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (valid0),
        .req_ready  (ready0),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_wdata  (req_wdata),
        .resp_valid (rv0),
        .resp_rdata (rd0),
        .resp_err   (err0),
        .busy       (busy0)
    );

    dmem_ctrl #(.ADDR_W(11), .WAIT_CYCLES(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (valid3),
        .req_ready  (ready3),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_wdata  (req_wdata),
        .resp_valid (rv3),
        .resp_rdata (rd3),
        .resp_err   (err3),
        .busy       (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: access width in bytes, aligned iff address is a multiple of the width.
    task automatic model_access(input int d, input logic we, input logic [10:0] a,
                                input logic [1:0] sz, input logic sg, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
        int n;
        int m;
        logic [31:0] v;
        m  = (d == 0) ? 0 : 1;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        rd = 32'h0;
        er = (sz == 2'd3) || ((int'(a) % n) != 0);
        if (!er) begin
            if (we) begin
                for (int i = 0; i < n; i++) mem_model[m][int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mem_model[m][int'(a) + i];
                if (sg && n < 4 && v[8*n-1]) begin
                    for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
                end
                rd = v;
            end
        end
    endtask

    // Drives one request and measures latency in cycles from the accepting edge; -1 on timeout.
    task automatic access(input int d, input logic we, input logic [10:0] a, input logic [1:0] sz,
                          input logic sg, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic [31:0] exp_rd, output logic exp_er);
        int guard;
        model_access(d, we, a, sz, sg, wd, exp_rd, exp_er);
        @(negedge clk);
        req_we = we; req_addr = a; req_size = sz; req_sign = sg; req_wdata = wd;
        if (d == 0) valid0 = 1'b1; else valid3 = 1'b1;
        guard = 0;
        while (!((d == 0) ? ready0 : ready3) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0;
        valid3 = 1'b0;
        lat = 1;
        while (!((d == 0) ? rv0 : rv3) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) lat = -1;
        rd = (d == 0) ? rd0 : rd3;
        er = (d == 0) ? err0 : err3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid0 = 1'b0; valid3 = 1'b0;
        req_we = 1'b0; req_addr = '0; req_size = 2'd0; req_sign = 1'b0; req_wdata = 32'h0;
        #3;
        checks++;
        if ({ready0, rv0, err0, busy0, rd0} !== {4'b1000, 32'h0}) begin
            errors++;
            $display("FAIL reset_dut0: got rdy/vld/err/busy %b%b%b%b rdata %h, want 1000 0",
                     ready0, rv0, err0, busy0, rd0);
        end
        checks++;
        if ({ready3, rv3, err3, busy3, rd3} !== {4'b1000, 32'h0}) begin
            errors++;
            $display("FAIL reset_dut3: got rdy/vld/err/busy %b%b%b%b rdata %h, want 1000 0",
                     ready3, rv3, err3, busy3, rd3);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd, erd; logic er, eer; int lat;
        access(0, 1'b1, 11'h010, 2'd2, 1'b0, 32'h12345678, rd, er, lat, erd, eer);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL word_store: got lat %0d err %b rdata %h, want 2 0 0", lat, er, rd);
        end
        access(0, 1'b0, 11'h010, 2'd2, 1'b0, 32'h0, rd, er, lat, erd, eer);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h12345678) begin
            errors++;
            $display("FAIL word_load: got lat %0d err %b rdata %h, want 2 0 12345678", lat, er, rd);
        end
        @(negedge clk);
        checks++;
        if (rv0 !== 1'b0 || rd0 !== 32'h12345678) begin
            errors++;
            $display("FAIL rdata_hold: got valid %b rdata %h, want 0 12345678", rv0, rd0);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd, erd; logic er, eer; int lat;
        access(0, 1'b1, 11'h013, 2'd0, 1'b0, 32'h00000080, rd, er, lat, erd, eer);
        access(0, 1'b0, 11'h013, 2'd0, 1'b1, 32'h0, rd, er, lat, erd, eer);
        checks++;
        if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
            errors++;
            $display("FAIL byte_signed: got %h err %b, want ffffff80 0", rd, er);
        end
        access(0, 1'b0, 11'h013, 2'd0, 1'b0, 32'h0, rd, er, lat, erd, eer);
        checks++;
        if (rd !== 32'h00000080) begin
            errors++;
            $display("FAIL byte_unsigned: got %h, want 00000080", rd);
        end
        access(0, 1'b0, 11'h010, 2'd2, 1'b1, 32'h0, rd, er, lat, erd, eer);
        checks++;
        if (rd !== 32'h80345678) begin
            errors++;
            $display("FAIL byte_merge: got %h, want 80345678", rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd, erd; logic er, eer; int lat;
        access(0, 1'b1, 11'h012, 2'd1, 1'b0, 32'h0000BEEF, rd, er, lat, erd, eer);
        access(0, 1'b0, 11'h012, 2'd1, 1'b1, 32'h0, rd, er, lat, erd, eer);
        checks++;
        if (rd !== 32'hFFFFBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL half_signed: got %h err %b, want ffffbeef 0", rd, er);
        end
        access(0, 1'b0, 11'h010, 2'd2, 1'b0, 32'h0, rd, er, lat, erd, eer);
        checks++;
        if (rd !== 32'hBEEF5678) begin
            errors++;
            $display("FAIL half_merge: got %h, want beef5678", rd);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, erd; logic er, eer; int lat;
        logic        we_t [3];
        logic [10:0] a_t  [3];
        logic [1:0]  sz_t [3];
        we_t = '{1'b1, 1'b0, 1'b0};
        a_t  = '{11'h011, 11'h012, 11'h010};
        sz_t = '{2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 3; i++) begin
            access(0, we_t[i], a_t[i], sz_t[i], 1'b0, 32'hAAAA5555, rd, er, lat, erd, eer);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
                errors++;
                $display("FAIL misaligned_%0d: got err %b rdata %h lat %0d, want 1 0 2",
                         i, er, rd, lat);
            end
        end
        access(0, 1'b0, 11'h010, 2'd2, 1'b0, 32'h0, rd, er, lat, erd, eer);
        checks++;
        if (rd !== 32'hBEEF5678) begin
            errors++;
            $display("FAIL misaligned_nowrite: got %h, want beef5678", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic        we_t [4];
        logic [10:0] a_t  [4];
        logic [1:0]  sz_t [4];
        logic [31:0] wd_t [4];
        logic [31:0] exp_rd [4];
        logic        exp_er [4];
        int          acc_c [4];
        int          n_acc, n_resp;
        bit          advance;
        we_t = '{1'b1, 1'b0, 1'b1, 1'b0};
        a_t  = '{11'h040, 11'h040, 11'h041, 11'h040};
        sz_t = '{2'd2, 2'd2, 2'd0, 2'd2};
        wd_t = '{$urandom, 32'h0, 32'h000000A5, 32'h0};
        for (int i = 0; i < 4; i++) begin
            model_access(3, we_t[i], a_t[i], sz_t[i], 1'b0, wd_t[i], exp_rd[i], exp_er[i]);
        end
        @(negedge clk);
        req_we = we_t[0]; req_addr = a_t[0]; req_size = sz_t[0]; req_sign = 1'b0;
        req_wdata = wd_t[0];
        valid3 = 1'b1;
        n_acc = 0; n_resp = 0; advance = 1'b0;
        for (int c = 0; c < 80 && n_resp < 4; c++) begin
            if (advance) begin
                advance = 1'b0;
                if (n_acc == 4) begin
                    valid3 = 1'b0;
                end else begin
                    req_we = we_t[n_acc]; req_addr = a_t[n_acc]; req_size = sz_t[n_acc];
                    req_wdata = wd_t[n_acc];
                end
            end
            if (rv3 && n_resp < n_acc) begin
                checks++;
                if (c - acc_c[n_resp] != 5 || rd3 !== exp_rd[n_resp] || err3 !== exp_er[n_resp])
                begin
                    errors++;
                    $display("FAIL b2b_resp_%0d: got lat %0d rdata %h err %b, want 5 %h %b",
                             n_resp, c - acc_c[n_resp], rd3, err3, exp_rd[n_resp], exp_er[n_resp]);
                end
                n_resp++;
            end else if (n_acc > n_resp) begin
                checks++;
                if (ready3 !== 1'b0 || busy3 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_stall: cycle %0d got ready %b busy %b, want 0 1",
                             c, ready3, busy3);
                end
            end
            if (valid3 && ready3) begin
                if (n_acc > 0) begin
                    checks++;
                    if (rv3 !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_accept_in_resp: req %0d got resp_valid %b, want 1",
                                 n_acc, rv3);
                    end
                end
                acc_c[n_acc] = c;
                n_acc++;
                advance = 1'b1;
            end
            @(negedge clk);
        end
        valid3 = 1'b0;
        checks++;
        if (n_resp != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses, want 4", n_resp);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd, erd; logic er, eer; int lat; bit seen;
        access(3, 1'b1, 11'h020, 2'd2, 1'b0, 32'h11223344, rd, er, lat, erd, eer);
        access(3, 1'b0, 11'h020, 2'd2, 1'b0, 32'h0, rd, er, lat, erd, eer);
        checks++;
        if (rd !== 32'h11223344 || lat !== 5) begin
            errors++;
            $display("FAIL pre_reset_load: got %h lat %0d, want 11223344 5", rd, lat);
        end
        @(negedge clk);
        req_we = 1'b1; req_addr = 11'h020; req_size = 2'd2; req_wdata = 32'hDEADBEEF;
        valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid3 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ready3, rv3, err3, busy3, rd3} !== {4'b1000, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid_op: got rdy/vld/err/busy %b%b%b%b rdata %h, want 1000 0",
                     ready3, rv3, err3, busy3, rd3);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rv3) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_resp: got a resp_valid after reset, want none");
        end
        access(3, 1'b0, 11'h020, 2'd2, 1'b0, 32'h0, rd, er, lat, erd, eer);
        checks++;
        if (rd !== 32'h11223344 || er !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_write: got %h err %b, want 11223344 0", rd, er);
        end
    endtask

    task automatic test_random(input int d, input logic [10:0] base, input int n_ops);
        logic [31:0] rd, erd; logic er, eer; int lat;
        logic        we;
        logic [10:0] a;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] wd;
        for (int w = 0; w < 16; w++) begin
            access(d, 1'b1, base + 11'(4 * w), 2'd2, 1'b0, $urandom, rd, er, lat, erd, eer);
        end
        for (int i = 0; i < n_ops; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = base + 11'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            wd = $urandom;
            access(d, we, a, sz, sg, wd, rd, er, lat, erd, eer);
            checks++;
            if (rd !== erd || er !== eer || lat != ((d == 0) ? 2 : 5)) begin
                errors++;
                $display("FAIL random_d%0d_%0d: we %b addr %h size %0d got %h/%b lat %0d, want %h/%b",
                         d, i, we, a, sz, rd, er, lat, erd, eer);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_op();
        test_random(0, 11'h100, 40);
        test_random(3, 11'h200, 12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
